dmem_access_ctrl: RTL and testbench

- Initiator-side controller for the single-cycle, level-sensitive data memory (16 x 32-bit words, word-indexed, with inputs memWrite/address/writedata and output readdata).
- Accepts load/store requests from the MEM pipeline stage over a valid/ready handshake and sequences memory accesses, including read-modify-write for byte/half stores.
- Returns load data with sign or zero extension, and returns a response (with error flag) for every accepted request.

---
 rtl/dmem_access_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// ----------------
// Initiator-side controller for a single-cycle, level-sensitive data memory
// of DEPTH x 32-bit words. Load/store requests from the MEM stage are taken
// over a valid/ready handshake. Byte and half stores are performed as
// read-modify-write. Every accepted request produces exactly one response.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both 1. The producer keeps its payload
// stable while valid=1 and ready=0. The request payload is only looked at
// while req_ready=1, and resp_ready only while resp_valid=1.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req_valid/ready   request handshake (req_ready high only in IDLE)
//   req_write         1 = store, 0 = load
//   req_size          0 = byte, 1 = half, 2 = word, 3 = illegal
//   req_signed        loads: 1 = sign-extend, 0 = zero-extend
//   req_addr          byte address
//   req_wdata         store data, right-aligned
//   resp_valid/ready  response handshake
//   resp_rdata        extended load data, 0 for stores and errors
//   resp_err          request rejected, memory untouched
//   mem_write         memory write strobe (level-sensitive memory)
//   mem_address       word index, upper bits always 0
//   mem_writedata     memory write data
//   mem_readdata      memory read data (combinational from mem_address)
//   dbg_state         current FSM state, for observation only
//
// All outputs come straight from flops.

module dmem_access_ctrl #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_writedata_q, mem_writedata_d;

    // Request fields latched at acceptance.
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] wdata_q, wdata_d;

    // Decode of the incoming request (only meaningful in IDLE).
    logic [IDX_W-1:0] req_idx;
    logic             req_bad;

    assign req_idx = req_addr[IDX_W+1:2];
    assign req_bad = (|req_addr[31:IDX_W+2])
                   || (req_size == 2'd1 && req_addr[0])
                   || (req_size == 2'd2 && req_addr[1:0] != 2'b00)
                   || (req_size == 2'd3);

    // Select the addressed lane of a little-endian word and extend it.
    function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off,
                                                 input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'd0:    extract_lane = {{24{sgn & b[7]}}, b};
            2'd1:    extract_lane = {{16{sgn & h[15]}}, h};
            default: extract_lane = word;
        endcase
    endfunction

    // Replace the addressed lane of the old word with new store data.
    function automatic logic [31:0] merge_lane(input logic [31:0] old,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic [15:0] wd);
        logic [31:0] r;
        r = old;
        if (size == 2'd0) begin
            r[{off, 3'b000} +: 8] = wd[7:0];
        end else if (off[1]) begin
            r[31:16] = wd;
        end else begin
            r[15:0] = wd;
        end
        merge_lane = r;
    endfunction

    always_comb begin
        state_d         = state_q;
        resp_rdata_d    = resp_rdata_q;
        resp_err_d      = resp_err_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        wr_d            = wr_q;
        size_d          = size_q;
        sgn_d           = sgn_q;
        off_d           = off_q;
        wdata_d         = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata[15:0];
                    if (req_bad) begin
                        // Address is left untouched: errors never reach memory.
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                        state_d      = S_RESP;
                    end else begin
                        mem_address_d = {{(32-IDX_W){1'b0}}, req_idx};
                        if (req_write && req_size == 2'd2) begin
                            mem_writedata_d = req_wdata;
                            state_d         = S_WRITE;
                        end else begin
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_READ: begin
                if (wr_q) begin
                    mem_writedata_d = merge_lane(mem_readdata, size_q, off_q, wdata_q);
                    state_d         = S_WRITE;
                end else begin
                    resp_rdata_d = extract_lane(mem_readdata, size_q, off_q, sgn_q);
                    resp_err_d   = 1'b0;
                    state_d      = S_RESP;
                end
            end
            S_WRITE: begin
                // Address and data hold on exit so the strobe falls first.
                resp_rdata_d = 32'd0;
                resp_err_d   = 1'b0;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered outputs follow the state being entered.
        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        mem_write_d  = (state_d == S_WRITE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= 32'd0;
            resp_err_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= 32'd0;
            mem_writedata_q <= 32'd0;
            wr_q            <= 1'b0;
            size_q          <= 2'd0;
            sgn_q           <= 1'b0;
            off_q           <= 2'd0;
            wdata_q         <= 16'd0;
        end else begin
            state_q         <= state_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_err_q      <= resp_err_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            wr_q            <= wr_d;
            size_q          <= size_d;
            sgn_q           <= sgn_d;
            off_q           <= off_d;
            wdata_q         <= wdata_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural 16-word memory.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    dmem_access_ctrl #(.DEPTH(16), .IDX_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .dbg_state     (dbg_state)
    );

    // ---------------- memory model + write monitor ----------------
    logic [31:0] mem [16];
    int          wr_cnt = 0;
    logic [31:0] last_wr_addr = 32'd0;
    logic [31:0] last_wr_data = 32'd0;

    assign mem_readdata = mem[mem_address[3:0]];

    always @(posedge clk) begin
        if (mem_write) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= mem_address;
            last_wr_data <= mem_writedata;
            mem[mem_address[3:0]] <= mem_writedata;
        end
    end

    // ---------------- scoreboard check ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Issues one request, returns response payload and latency (cycles from
    // the acceptance edge to the first cycle with resp_valid=1). If
    // resp_ready=1 the response handshake is completed too.
    task automatic txn(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
        int w;
        @(negedge clk);
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!resp_valid) chk("resp_timeout", {31'd0, resp_valid}, 32'd1);
        rdata = resp_rdata;
        err   = resp_err;
        if (resp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          w0;

        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready",  {31'd0, req_ready},  32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata,          32'd0);
        chk("rst_resp_err",   {31'd0, resp_err},   32'd0);
        chk("rst_mem_write",  {31'd0, mem_write},  32'd0);
        chk("rst_mem_addr",   mem_address,         32'd0);
        chk("rst_mem_wdata",  mem_writedata,       32'd0);
        @(negedge clk);
        reset = 1'b0;
        mem[3] = 32'h11223344;
        mem[1] = 32'h0000F080;

        // Word store then load
        w0 = wr_cnt;
        txn(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, rd, er, lat);
        chk("wst_lat",     lat,          2);
        chk("wst_err",     {31'd0, er},  32'd0);
        chk("wst_rdata",   rd,           32'd0);
        chk("wst_wr_cnt",  wr_cnt - w0,  1);
        chk("wst_wr_addr", last_wr_addr, 32'd2);
        chk("wst_mem",     mem[2],       32'hDEADBEEF);
        txn(1'b0, 2'd2, 1'b0, 32'h08, 32'd0, rd, er, lat);
        chk("wld_lat",   lat,         2);
        chk("wld_rdata", rd,          32'hDEADBEEF);
        chk("wld_err",   {31'd0, er}, 32'd0);

        // Byte store read-modify-write
        w0 = wr_cnt;
        txn(1'b1, 2'd0, 1'b0, 32'h0D, 32'h000000AA, rd, er, lat);
        chk("bst_lat",     lat,          3);
        chk("bst_wr_cnt",  wr_cnt - w0,  1);
        chk("bst_wr_data", last_wr_data, 32'h1122AA44);
        chk("bst_wr_addr", last_wr_addr, 32'd3);
        chk("bst_mem",     mem[3],       32'h1122AA44);
        chk("bst_err",     {31'd0, er},  32'd0);

        // Sign and zero extension on word 1 = 0x0000F080
        txn(1'b0, 2'd0, 1'b1, 32'h04, 32'd0, rd, er, lat);
        chk("ld_sb",  rd, 32'hFFFFFF80);
        txn(1'b0, 2'd0, 1'b0, 32'h04, 32'd0, rd, er, lat);
        chk("ld_ub",  rd, 32'h00000080);
        txn(1'b0, 2'd1, 1'b1, 32'h04, 32'd0, rd, er, lat);
        chk("ld_sh0", rd, 32'hFFFFF080);
        txn(1'b0, 2'd1, 1'b1, 32'h06, 32'd0, rd, er, lat);
        chk("ld_sh2", rd, 32'h00000000);
        chk("ld_lat", lat, 2);

        // Half store into the upper half of word 1
        txn(1'b1, 2'd1, 1'b0, 32'h06, 32'h1234BEEF, rd, er, lat);
        chk("hst_lat", lat,    3);
        chk("hst_mem", mem[1], 32'hBEEFF080);

        // Errors: misaligned word, misaligned half, out of range, size 3
        w0 = wr_cnt;
        txn(1'b0, 2'd2, 1'b0, 32'h0A, 32'd0, rd, er, lat);
        chk("e1_err", {31'd0, er}, 32'd1);
        chk("e1_lat", lat, 1);
        chk("e1_rd",  rd, 32'd0);
        txn(1'b1, 2'd1, 1'b0, 32'h03, 32'h5555, rd, er, lat);
        chk("e2_err", {31'd0, er}, 32'd1);
        chk("e2_lat", lat, 1);
        chk("e2_rd",  rd, 32'd0);
        txn(1'b0, 2'd0, 1'b0, 32'h40, 32'd0, rd, er, lat);
        chk("e3_err", {31'd0, er}, 32'd1);
        chk("e3_lat", lat, 1);
        chk("e3_rd",  rd, 32'd0);
        txn(1'b1, 2'd3, 1'b0, 32'h00, 32'hFFFFFFFF, rd, er, lat);
        chk("e4_err", {31'd0, er}, 32'd1);
        chk("e4_lat", lat, 1);
        chk("e4_rd",  rd, 32'd0);
        chk("err_no_write", wr_cnt - w0, 0);

        // Response backpressure on a load from word 2
        resp_ready = 1'b0;
        txn(1'b0, 2'd2, 1'b0, 32'h08, 32'd0, rd, er, lat);
        chk("bp_rdata", rd, 32'hDEADBEEF);
        // Offer a store while the response is stalled; it must not be taken.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h00;
        req_wdata = 32'hCAFEF00D;
        w0 = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid",     {31'd0, resp_valid}, 32'd1);
            chk("bp_rdata_hold", resp_rdata,         32'hDEADBEEF);
            chk("bp_req_ready", {31'd0, req_ready},  32'd0);
        end
        req_valid = 1'b0;
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_done_valid", {31'd0, resp_valid}, 32'd0);
        chk("bp_done_ready", {31'd0, req_ready},  32'd1);
        chk("bp_no_write",   wr_cnt - w0,         0);
        chk("bp_mem0",       mem[0],              32'd0);

        // Reset during the READ cycle of a byte store to word 3
        w0 = wr_cnt;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'h0C;
        req_wdata  = 32'h00000055;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rr_in_read_addr", mem_address, 32'd3);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rr_req_ready",  {31'd0, req_ready},  32'd1);
        chk("rr_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rr_resp_rdata", resp_rdata,          32'd0);
        chk("rr_resp_err",   {31'd0, resp_err},   32'd0);
        chk("rr_mem_write",  {31'd0, mem_write},  32'd0);
        chk("rr_mem_addr",   mem_address,         32'd0);
        chk("rr_mem_wdata",  mem_writedata,       32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rr_no_resp",  {31'd0, resp_valid}, 32'd0);
        chk("rr_no_write", wr_cnt - w0,         0);
        chk("rr_mem3",     mem[3],              32'h1122AA44);

        // Controller still usable after the reset
        txn(1'b0, 2'd0, 1'b0, 32'h0D, 32'd0, rd, er, lat);
        chk("post_rst_ld", rd, 32'h000000AA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
